// File: rtl/prbs_test_sched.sv
// Round-robin controller sharing one PRBS generator / pattern-detector datapath
// between two test requesters; returns pass/fail with a cycle count and keeps statistics.
module prbs_test_sched #(
    parameter int SLACK      = 8,
    parameter int RST_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_pattern,
    input  logic [15:0] req_n,
    output logic        dp_rst_n,
    output logic [31:0] dp_in,
    output logic [7:0]  dp_n,
    input  logic        dp_pattern_detected,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic        rsp_pass,
    output logic [15:0] rsp_cycles,
    output logic [15:0] pass_cnt,
    output logic [15:0] fail_cnt
);

    typedef enum logic [1:0] {IDLE, HOLD, RUN, RESP} state_t;

    state_t      state, state_next;
    logic        rr_ptr;
    logic [3:0]  hold_cnt;
    logic [15:0] run_cnt;
    logic        winner;
    logic        accept;
    logic        hold_done;
    logic [31:0] win_pattern;
    logic [7:0]  win_n;
    logic [15:0] cnt_next;
    logic [15:0] deadline;

    // On a tie the requester after the last winner goes next.
    assign winner      = (req_valid == 2'b11) ? ~rr_ptr : req_valid[1];
    assign win_pattern = winner ? req_pattern[63:32] : req_pattern[31:0];
    assign win_n       = winner ? req_n[15:8] : req_n[7:0];
    assign deadline    = {6'd0, dp_n, 2'b00} + 16'(SLACK);
    assign cnt_next    = run_cnt + 16'd1;
    assign hold_done   = (hold_cnt == 4'(RST_CYCLES - 1));
    assign rsp_valid   = (state == RESP);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= IDLE;
        else       state <= state_next;
    end

    // Grants are gated by RSTn so no requester is accepted while reset is held.
    always_comb begin
        state_next = state;
        req_ready  = 2'b00;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (RSTn && (req_valid != 2'b00)) begin
                    accept     = 1'b1;
                    req_ready  = winner ? 2'b10 : 2'b01;
                    state_next = (win_n == 8'd0) ? RESP : HOLD;
                end
            end
            HOLD: begin
                if (hold_done) state_next = RUN;
            end
            RUN: begin
                if (dp_pattern_detected || (cnt_next == deadline)) state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            dp_rst_n   <= 1'b0;
            dp_in      <= 32'd0;
            dp_n       <= 8'd0;
            rsp_id     <= 1'b0;
            rsp_pass   <= 1'b0;
            rsp_cycles <= 16'd0;
            pass_cnt   <= 16'd0;
            fail_cnt   <= 16'd0;
            rr_ptr     <= 1'b1;
            hold_cnt   <= 4'd0;
            run_cnt    <= 16'd0;
        end else begin
            dp_rst_n <= (state_next == RUN);
            case (state)
                IDLE: begin
                    if (accept) begin
                        dp_in      <= win_pattern;
                        dp_n       <= win_n;
                        rsp_id     <= winner;
                        rr_ptr     <= winner;
                        rsp_pass   <= 1'b0;
                        rsp_cycles <= 16'd0;
                        hold_cnt   <= 4'd0;
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + 4'd1;
                    run_cnt  <= 16'd0;
                end
                RUN: begin
                    run_cnt <= cnt_next;
                    if (state_next == RESP) begin
                        rsp_pass   <= dp_pattern_detected;
                        rsp_cycles <= cnt_next;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        if (rsp_pass) begin
                            if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
                        end else begin
                            if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prbs_test_sched.sv
// Directed scoreboard bench for prbs_test_sched; a small datapath model raises
// detect at a chosen RUN cycle and expected responses are predicted at grant time.
module tb_prbs_test_sched;

    typedef struct packed {
        logic        id;
        logic        pass;
        logic [15:0] cycles;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_pattern;
    logic [15:0] req_n;
    logic        dp_rst_n;
    logic [31:0] dp_in;
    logic [7:0]  dp_n;
    logic        dp_pattern_detected;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic        rsp_pass;
    logic [15:0] rsp_cycles;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;

    exp_t sb[$];
    int   checks_total  = 0;
    int   checks_passed = 0;
    int   model_pass    = 0;
    int   model_fail    = 0;
    int   detect_at     = 0;
    int   run_seen      = 0;
    int   high_total    = 0;

    prbs_test_sched #(.SLACK(8), .RST_CYCLES(2)) dut (
        .CLK                 (CLK),
        .RSTn                (RSTn),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_pattern         (req_pattern),
        .req_n               (req_n),
        .dp_rst_n            (dp_rst_n),
        .dp_in               (dp_in),
        .dp_n                (dp_n),
        .dp_pattern_detected (dp_pattern_detected),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_id              (rsp_id),
        .rsp_pass            (rsp_pass),
        .rsp_cycles          (rsp_cycles),
        .pass_cnt            (pass_cnt),
        .fail_cnt            (fail_cnt)
    );

    initial forever #5 CLK = ~CLK;

    // Datapath model: counts cycles with dp_rst_n high and pulses detect in cycle detect_at.
    initial begin
        dp_pattern_detected = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (dp_rst_n === 1'b1) begin
                run_seen++;
                high_total++;
            end else begin
                run_seen = 0;
            end
            dp_pattern_detected = (detect_at != 0) && (run_seen == detect_at);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t predict(input logic id, input logic [7:0] n);
        exp_t e;
        int   dl;
        dl   = 4 * int'(n) + 8;
        e.id = id;
        if (n == 8'd0) begin
            e.pass   = 1'b0;
            e.cycles = 16'd0;
        end else if (detect_at != 0 && detect_at <= dl) begin
            e.pass   = 1'b1;
            e.cycles = 16'(detect_at);
        end else begin
            e.pass   = 1'b0;
            e.cycles = 16'(dl);
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic id, input logic [31:0] pattern, input logic [7:0] n);
        int k;
        k = 0;
        @(negedge CLK);
        req_pattern = 64'd0;
        req_n       = 16'd0;
        if (id) begin
            req_valid          = 2'b10;
            req_pattern[63:32] = pattern;
            req_n[15:8]        = n;
        end else begin
            req_valid          = 2'b01;
            req_pattern[31:0]  = pattern;
            req_n[7:0]         = n;
        end
        #1;
        while (req_ready[id] !== 1'b1 && k < 100) begin
            @(negedge CLK);
            #1;
            k++;
        end
        checkOutput("grant_ready", {30'd0, req_ready}, id ? 32'd2 : 32'd1);
        sb.push_back(predict(id, n));
        @(posedge CLK);
        #1;
        req_valid   = 2'b00;
        req_pattern = ~req_pattern;
        req_n       = ~req_n;
        checkOutput("dp_in", dp_in, pattern);
        checkOutput("dp_n", {24'd0, dp_n}, {24'd0, n});
        checkOutput("dp_rst_n_after_grant", {31'd0, dp_rst_n}, 32'd0);
    endtask

    task automatic waitResponse(input int stall);
        exp_t e;
        int   k;
        k = 0;
        e = '1;
        @(negedge CLK);
        while (rsp_valid !== 1'b1 && k < 300) begin
            @(negedge CLK);
            k++;
        end
        checkOutput("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        if (sb.size() > 0) e = sb.pop_front();
        checkOutput("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
        checkOutput("rsp_pass", {31'd0, rsp_pass}, {31'd0, e.pass});
        checkOutput("rsp_cycles", {16'd0, rsp_cycles}, {16'd0, e.cycles});
        checkOutput("run_length", high_total, {16'd0, e.cycles});
        high_total = 0;
        if (stall > 0) begin
            req_valid = 2'b11;
            for (int i = 0; i < stall; i++) begin
                @(negedge CLK);
                checkOutput("stall_valid", {31'd0, rsp_valid}, 32'd1);
                checkOutput("stall_cycles", {16'd0, rsp_cycles}, {16'd0, e.cycles});
                checkOutput("stall_pass", {31'd0, rsp_pass}, {31'd0, e.pass});
                checkOutput("stall_no_grant", {30'd0, req_ready}, 32'd0);
            end
            req_valid = 2'b00;
        end
        rsp_ready = 1'b1;
        @(posedge CLK);
        #1;
        rsp_ready = 1'b0;
        if (e.pass) model_pass++;
        else        model_fail++;
        checkOutput("pass_cnt", {16'd0, pass_cnt}, model_pass);
        checkOutput("fail_cnt", {16'd0, fail_cnt}, model_fail);
        checkOutput("dp_rst_n_idle", {31'd0, dp_rst_n}, 32'd0);
    endtask

    initial begin
        int k;
        RSTn        = 1'b0;
        req_valid   = 2'b11;
        req_pattern = {64{1'b1}};
        req_n       = 16'hFFFF;
        rsp_ready   = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("reset_req_ready", {30'd0, req_ready}, 32'd0);
        checkOutput("reset_dp_rst_n", {31'd0, dp_rst_n}, 32'd0);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_pass_cnt", {16'd0, pass_cnt}, 32'd0);
        checkOutput("reset_fail_cnt", {16'd0, fail_cnt}, 32'd0);
        checkOutput("reset_dp_in", dp_in, 32'd0);
        checkOutput("reset_rsp_cycles", {16'd0, rsp_cycles}, 32'd0);
        req_valid = 2'b00;
        RSTn      = 1'b1;

        $display("[TB] single pass");
        detect_at = 9;
        applyStimulus(1'b0, 32'hABCDEFCD, 8'd2);
        @(negedge CLK);
        checkOutput("hold_cycle1", {31'd0, dp_rst_n}, 32'd0);
        @(negedge CLK);
        checkOutput("hold_cycle2", {31'd0, dp_rst_n}, 32'd0);
        @(negedge CLK);
        checkOutput("run_cycle1", {31'd0, dp_rst_n}, 32'd1);
        waitResponse(0);

        $display("[TB] timeout with held response");
        detect_at = 0;
        applyStimulus(1'b1, 32'h13579BDF, 8'd3);
        waitResponse(5);

        $display("[TB] round robin");
        detect_at   = 3;
        req_pattern = {32'h11112222, 32'h33334444};
        req_n       = {8'd1, 8'd1};
        req_valid   = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic gid;
            gid = i[0];
            k   = 0;
            @(negedge CLK);
            while (req_ready === 2'b00 && k < 100) begin
                @(negedge CLK);
                k++;
            end
            checkOutput("rr_grant", {30'd0, req_ready}, gid ? 32'd2 : 32'd1);
            sb.push_back(predict(gid, 8'd1));
            @(posedge CLK);
            #1;
            checkOutput("rr_dp_in", dp_in, gid ? 32'h11112222 : 32'h33334444);
            waitResponse(0);
        end
        req_valid = 2'b00;

        $display("[TB] zero repeat count");
        detect_at = 1;
        applyStimulus(1'b0, 32'h0F0F0F0F, 8'd0);
        waitResponse(0);

        $display("[TB] detect in deadline cycle");
        detect_at = 12;
        applyStimulus(1'b1, 32'h5A5A5A5A, 8'd1);
        waitResponse(0);

        $display("[TB] reset mid run");
        detect_at = 0;
        applyStimulus(1'b1, 32'h76543210, 8'd5);
        k = 0;
        while (run_seen != 3 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        checkOutput("mid_run_reached", run_seen, 32'd3);
        RSTn = 1'b0;
        #1;
        checkOutput("abort_dp_rst_n", {31'd0, dp_rst_n}, 32'd0);
        checkOutput("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("abort_pass_cnt", {16'd0, pass_cnt}, 32'd0);
        checkOutput("abort_fail_cnt", {16'd0, fail_cnt}, 32'd0);
        checkOutput("abort_dp_in", dp_in, 32'd0);
        sb.delete();
        model_pass = 0;
        model_fail = 0;
        @(negedge CLK);
        high_total = 0;
        RSTn       = 1'b1;
        @(negedge CLK);
        checkOutput("no_rsp_after_abort", {31'd0, rsp_valid}, 32'd0);
        detect_at = 5;
        applyStimulus(1'b0, 32'hCAFEF00D, 8'd2);
        waitResponse(0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/prbs_test_sched.md
Name: prbs_test_sched

Overview:
- Round-robin scheduler/controller that shares one PRBS generator + pattern-detector datapath between two test requesters.
- Grants one request at a time, loads its 32-bit pattern and repeat count n into the datapath, and releases the datapath reset.
- Waits for pattern_detected or a deadline, then returns a pass/fail response with a cycle count.
- Sits between the requester logic and the PRBS_PD datapath; keeps saturating pass/fail statistics.

Parameters:
- SLACK, 8: extra cycles beyond 4*n allowed before a run is declared failed.
- RST_CYCLES, 2: cycles dp_rst_n is held low after a grant, before the run starts (range 1..15).

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept, combinational; at most one bit high.
- req_pattern  in  64  requester i pattern = bits [32i+31:32i].
- req_n  in  16  requester i repeat count = bits [8i+7:8i].
- dp_rst_n  out  1  datapath active-low reset (registered).
- dp_in  out  32  pattern to datapath (registered).
- dp_n  out  8  repeat count to datapath (registered).
- dp_pattern_detected  in  1  datapath detection flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  requester index of the response.
- rsp_pass  out  1  1 = pattern detected, 0 = timeout or rejected.
- rsp_cycles  out  16  RUN cycles consumed.
- pass_cnt  out  16  saturating count of passes.
- fail_cnt  out  16  saturating count of fails.

Behaviour:
- Reset, async: state=IDLE, rr pointer=1 so requester 0 wins the first tie. Outputs during reset: dp_rst_n=0, dp_in=0, dp_n=0, rsp_valid=0, rsp_id=0, rsp_pass=0, rsp_cycles=0, pass_cnt=0, fail_cnt=0, req_ready=0.
- Reset mid-run aborts the run with no response.
- States: IDLE, HOLD, RUN, RESP.
- dp_rst_n is 0 in every state except RUN.
- IDLE:
  - Arbitrate among req_valid bits; on a tie, grant the requester after the rr pointer. Assert req_ready for the winner only.
  - Transfer occurs on valid&ready. Next cycle: latch dp_in/dp_n, set rsp_id, set rr pointer = winner.
  - If the latched n==0: go to RESP with rsp_pass=0, rsp_cycles=0, and do not run the datapath.
  - Else go to HOLD.
- HOLD: stay RST_CYCLES cycles, then go to RUN; the cycle counter is cleared on entry to RUN.
- RUN:
  - dp_rst_n=1. The counter increments every cycle; the first RUN cycle counts as 1.
  - dp_pattern_detected sampled high -> RESP, rsp_pass=1, rsp_cycles=count.
  - Otherwise, when count == 4*n+SLACK -> RESP, rsp_pass=0, rsp_cycles=4*n+SLACK.
  - Detection in the deadline cycle counts as a pass.
  - Deadline arithmetic uses 16 bits; no overflow (max 1020+SLACK).
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_valid&rsp_ready: increment pass_cnt or fail_cnt (saturate at 16'hFFFF), return to IDLE.
  - req_ready=0 throughout HOLD/RUN/RESP.
- dp_in/dp_n retain the last granted values until the next grant.
- Requester inputs only need to be stable in the accept cycle.

Test Plan:
- Reset: hold RSTn=0 with req_valid=2'b11 -> req_ready=0, dp_rst_n=0, rsp_valid=0, counters 0.
- Single pass:
  - Stimulus: requester 0, pattern 32'hABCDEFCD, n=2; bench datapath model asserts detect at RUN cycle 9.
  - Response: dp_in=32'hABCDEFCD, dp_n=2, dp_rst_n low for 2 cycles then high; rsp_id=0, rsp_pass=1, rsp_cycles=9, pass_cnt=1.
- Timeout:
  - Stimulus: requester 1, n=3, detect never asserted.
  - Response: rsp_pass=0, rsp_cycles=20 (4*3+8), fail_cnt=1, dp_rst_n returns to 0.
- Round-robin: both requesters continuously valid for 4 requests -> grant order 0,1,0,1; each rsp_id matches its grant.
- Edge cases:
  - n=0 request -> immediate response: rsp_pass=0, rsp_cycles=0, dp_rst_n never high.
  - Detect in the deadline cycle (count=4n+8) -> rsp_pass=1.
  - rsp_ready held low 5 cycles -> response held stable, no new grant.
- Reset mid-RUN: drop RSTn at RUN cycle 3 -> immediate IDLE outputs, no response, counters cleared; the next request runs normally.
